// File: rtl/cva6_lsu_sched_if.sv
// Issue-side and memory-side handshake bundle for the LSU scheduler.
// The slave modport is the scheduler's view; master is the issue stage and memory together.
interface cva6_lsu_sched_if #(
    parameter int unsigned ADDR_W = 32
);
    logic [ADDR_W-1:0] instr_i;
    logic              is_load_i;
    logic              instr_valid_i;
    logic              ready_o;
    logic              mem_req_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic              mem_gnt_i;
    logic              load_mem_resp_i;
    logic              store_mem_resp_i;
    logic              stq_full_o;

    modport slave (
        input  instr_i, is_load_i, instr_valid_i, mem_gnt_i, load_mem_resp_i, store_mem_resp_i,
        output ready_o, mem_req_o, mem_we_o, mem_addr_o, stq_full_o
    );

    modport master (
        output instr_i, is_load_i, instr_valid_i, mem_gnt_i, load_mem_resp_i, store_mem_resp_i,
        input  ready_o, mem_req_o, mem_we_o, mem_addr_o, stq_full_o
    );
endinterface

// File: rtl/cva6_lsu_sched.sv
// LSU scheduler: one outstanding load plus an in-order store queue, arbitrated onto a
// single memory request port with a request lock that holds until grant.
module cva6_lsu_sched #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned STQ_DEPTH = 2
) (
    input logic             clk_i,
    input logic             rst_i,
    cva6_lsu_sched_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(STQ_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        LD_IDLE = 2'd0,
        LD_PEND = 2'd1,
        LD_WAIT = 2'd2
    } ld_state_e;

    ld_state_e         ld_state_q, ld_state_d;
    logic [ADDR_W-1:0] ld_addr_q;

    logic [ADDR_W-1:0]    stq_addr_q [STQ_DEPTH];
    logic [STQ_DEPTH-1:0] stq_valid_q;
    logic [STQ_DEPTH-1:0] stq_issued_q;
    logic [PTR_W-1:0]     head_q, tail_q;
    logic [CNT_W-1:0]     cnt_q;

    logic              lock_q;
    logic              lock_we_q;
    logic [ADDR_W-1:0] lock_addr_q;

    logic              stq_full, hazard, ready_c, accept, push, pop;
    logic              load_elig, store_elig, req_c, we_c, gnt;
    logic [ADDR_W-1:0] addr_c;

    assign stq_full   = cnt_q == CNT_W'(STQ_DEPTH);
    assign ready_c    = !rst_i && (ld_state_q == LD_IDLE) && !stq_full;
    assign accept     = bus.instr_valid_i && ready_c;
    assign push       = accept && !bus.is_load_i;
    assign pop        = bus.store_mem_resp_i && stq_valid_q[head_q] && stq_issued_q[head_q];
    assign load_elig  = (ld_state_q == LD_PEND) && !hazard;
    assign store_elig = stq_valid_q[head_q] && !stq_issued_q[head_q];
    assign gnt        = req_c && bus.mem_gnt_i;

    // Word-granular match of the pending load against every live store entry
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < int'(STQ_DEPTH); i++) begin
            if (stq_valid_q[i] && (stq_addr_q[i][ADDR_W-1:2] == ld_addr_q[ADDR_W-1:2])) begin
                hazard = 1'b1;
            end
        end
    end

    // Locked request replays the latched beat; otherwise arbitrate fresh
    always_comb begin
        req_c  = 1'b0;
        we_c   = 1'b0;
        addr_c = '0;
        if (lock_q) begin
            req_c  = 1'b1;
            we_c   = lock_we_q;
            addr_c = lock_addr_q;
        end else if (load_elig && !(stq_full && store_elig)) begin
            req_c  = 1'b1;
            addr_c = ld_addr_q;
        end else if (store_elig) begin
            req_c  = 1'b1;
            we_c   = 1'b1;
            addr_c = stq_addr_q[head_q];
        end
    end

    assign bus.ready_o    = ready_c;
    assign bus.mem_req_o  = req_c && !rst_i;
    assign bus.mem_we_o   = we_c && !rst_i;
    assign bus.mem_addr_o = rst_i ? '0 : addr_c;
    assign bus.stq_full_o = stq_full && !rst_i;

    always_comb begin
        ld_state_d = ld_state_q;
        case (ld_state_q)
            LD_IDLE: if (accept && bus.is_load_i) ld_state_d = LD_PEND;
            LD_PEND: if (gnt && !we_c)            ld_state_d = LD_WAIT;
            LD_WAIT: if (bus.load_mem_resp_i)     ld_state_d = LD_IDLE;
            default:                              ld_state_d = LD_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ld_state_q   <= LD_IDLE;
            stq_valid_q  <= '0;
            stq_issued_q <= '0;
            head_q       <= '0;
            tail_q       <= '0;
            cnt_q        <= '0;
            lock_q       <= 1'b0;
            lock_we_q    <= 1'b0;
            lock_addr_q  <= '0;
        end else begin
            ld_state_q <= ld_state_d;
            if (push) begin
                stq_valid_q[tail_q]  <= 1'b1;
                stq_issued_q[tail_q] <= 1'b0;
                tail_q               <= tail_q + PTR_W'(1);
            end
            if (gnt && we_c) begin
                stq_issued_q[head_q] <= 1'b1;
            end
            if (pop) begin
                stq_valid_q[head_q]  <= 1'b0;
                stq_issued_q[head_q] <= 1'b0;
                head_q               <= head_q + PTR_W'(1);
            end
            cnt_q <= cnt_q + CNT_W'(push) - CNT_W'(pop);
            // Lock drops on grant so the next beat is arbitrated the following cycle
            if (lock_q) begin
                lock_q <= !bus.mem_gnt_i;
            end else if (req_c && !bus.mem_gnt_i) begin
                lock_q      <= 1'b1;
                lock_we_q   <= we_c;
                lock_addr_q <= addr_c;
            end
        end
    end

    // Address payloads carry no control meaning and need no reset
    always_ff @(posedge clk_i) begin
        if (accept && bus.is_load_i) begin
            ld_addr_q <= bus.instr_i;
        end
        if (push) begin
            stq_addr_q[tail_q] <= bus.instr_i;
        end
    end
endmodule

// File: tb/tb_cva6_lsu_sched.sv
// Directed bench for cva6_lsu_sched: a cycle table on a 2-entry queue instance plus a
// hand sequence on a 4-entry instance where a pending store and load contend.
module tb_cva6_lsu_sched;
    localparam int unsigned ADDR_W = 32;

    logic clk;
    logic rst2;
    logic rst4;

    cva6_lsu_sched_if #(.ADDR_W(ADDR_W)) bus2 ();
    cva6_lsu_sched_if #(.ADDR_W(ADDR_W)) bus4 ();

    cva6_lsu_sched #(.ADDR_W(ADDR_W), .STQ_DEPTH(2)) u_dut2 (
        .clk_i (clk),
        .rst_i (rst2),
        .bus   (bus2)
    );

    cva6_lsu_sched #(.ADDR_W(ADDR_W), .STQ_DEPTH(4)) u_dut4 (
        .clk_i (clk),
        .rst_i (rst4),
        .bus   (bus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        vld;
        logic        ld;
        logic [31:0] instr;
        logic        gnt;
        logic        lr;
        logic        sr;
        logic        e_rdy;
        logic        e_req;
        logic        e_we;
        logic [31:0] e_addr;
        logic        e_full;
        logic        chk_wa;
    } vec_t;

    vec_t vecs[$];
    int   n_tests;
    int   n_fail;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic rst, input logic vld, input logic ld,
                                input logic [31:0] instr, input logic gnt, input logic lr,
                                input logic sr, input logic e_rdy, input logic e_req,
                                input logic e_we, input logic [31:0] e_addr,
                                input logic e_full, input logic chk_wa);
        vec_t v;
        v.rst = rst;  v.vld = vld;  v.ld = ld;  v.instr = instr;
        v.gnt = gnt;  v.lr = lr;    v.sr = sr;
        v.e_rdy = e_rdy;  v.e_req = e_req;  v.e_we = e_we;
        v.e_addr = e_addr;  v.e_full = e_full;  v.chk_wa = chk_wa;
        return v;
    endfunction

    task automatic drive4(input logic vld, input logic ld, input logic [31:0] instr,
                          input logic gnt, input logic lr, input logic sr);
        bus4.instr_valid_i    = vld;
        bus4.is_load_i        = ld;
        bus4.instr_i          = instr;
        bus4.mem_gnt_i        = gnt;
        bus4.load_mem_resp_i  = lr;
        bus4.store_mem_resp_i = sr;
    endtask

    task automatic check4(input string tag, input logic e_rdy, input logic e_req,
                          input logic e_we, input logic [31:0] e_addr, input logic e_full);
        check({tag, " ready"}, 32'(bus4.ready_o), 32'(e_rdy));
        check({tag, " req"}, 32'(bus4.mem_req_o), 32'(e_req));
        if (e_req) begin
            check({tag, " we"}, 32'(bus4.mem_we_o), 32'(e_we));
            check({tag, " addr"}, bus4.mem_addr_o, e_addr);
        end
        check({tag, " full"}, 32'(bus4.stq_full_o), 32'(e_full));
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst2 = 1'b1;
        rst4 = 1'b1;
        bus2.instr_valid_i = 1'b0;  bus2.is_load_i = 1'b0;  bus2.instr_i = '0;
        bus2.mem_gnt_i = 1'b0;  bus2.load_mem_resp_i = 1'b0;  bus2.store_mem_resp_i = 1'b0;
        drive4(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

        //                 rst vld ld  instr     gnt lr  sr   rdy req we  addr      full chk
        // reset hold, then release with spurious gnt/resp
        vecs.push_back(mk(1, 0, 0, 32'h0,     0, 0, 0,   0, 0, 0, 32'h0,   0, 1));
        vecs.push_back(mk(1, 0, 0, 32'h0,     0, 0, 0,   0, 0, 0, 32'h0,   0, 1));
        vecs.push_back(mk(0, 0, 0, 32'h0,     1, 1, 1,   1, 0, 0, 32'h0,   0, 1));
        // load 0xcad, grant one cycle after request, response three cycles after grant
        vecs.push_back(mk(0, 1, 1, 32'hcad,   0, 0, 0,   1, 0, 0, 32'h0,   0, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,     0, 0, 0,   0, 1, 0, 32'hcad, 0, 1));
        vecs.push_back(mk(0, 0, 0, 32'h0,     1, 0, 0,   0, 1, 0, 32'hcad, 0, 1));
        vecs.push_back(mk(0, 0, 0, 32'h0,     0, 0, 0,   0, 0, 0, 32'h0,   0, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,     0, 0, 0,   0, 0, 0, 32'h0,   0, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,     0, 1, 0,   0, 0, 0, 32'h0,   0, 0));
        // two back-to-back stores fill the queue; head request held until grant
        vecs.push_back(mk(0, 1, 0, 32'h100,   0, 0, 0,   1, 0, 0, 32'h0,   0, 0));
        vecs.push_back(mk(0, 1, 0, 32'h104,   0, 0, 0,   1, 1, 1, 32'h100, 0, 1));
        vecs.push_back(mk(0, 0, 0, 32'h0,     0, 0, 0,   0, 1, 1, 32'h100, 1, 1));
        vecs.push_back(mk(0, 0, 0, 32'h0,     1, 0, 0,   0, 1, 1, 32'h100, 1, 1));
        vecs.push_back(mk(0, 0, 0, 32'h0,     0, 0, 1,   0, 0, 0, 32'h0,   1, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,     1, 0, 0,   1, 1, 1, 32'h104, 0, 1));
        vecs.push_back(mk(0, 0, 0, 32'h0,     0, 0, 1,   1, 0, 0, 32'h0,   0, 0));
        // store 0xcac then load 0xcad in the same word: load waits for the store response
        vecs.push_back(mk(0, 1, 0, 32'hcac,   0, 0, 0,   1, 0, 0, 32'h0,   0, 0));
        vecs.push_back(mk(0, 1, 1, 32'hcad,   0, 0, 0,   1, 1, 1, 32'hcac, 0, 1));
        vecs.push_back(mk(0, 0, 0, 32'h0,     1, 0, 0,   0, 1, 1, 32'hcac, 0, 1));
        vecs.push_back(mk(0, 0, 0, 32'h0,     0, 0, 0,   0, 0, 0, 32'h0,   0, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,     0, 0, 1,   0, 0, 0, 32'h0,   0, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,     1, 0, 0,   0, 1, 0, 32'hcad, 0, 1));
        vecs.push_back(mk(0, 0, 0, 32'h0,     0, 1, 0,   0, 0, 0, 32'h0,   0, 0));
        // store then load in flight, reset during load wait, late responses ignored
        vecs.push_back(mk(0, 1, 0, 32'h400,   0, 0, 0,   1, 0, 0, 32'h0,   0, 0));
        vecs.push_back(mk(0, 1, 1, 32'h040,   1, 0, 0,   1, 1, 1, 32'h400, 0, 1));
        vecs.push_back(mk(0, 0, 0, 32'h0,     1, 0, 0,   0, 1, 0, 32'h040, 0, 1));
        vecs.push_back(mk(1, 0, 0, 32'h0,     0, 0, 0,   0, 0, 0, 32'h0,   0, 1));
        vecs.push_back(mk(0, 0, 0, 32'h0,     0, 1, 1,   1, 0, 0, 32'h0,   0, 1));
        vecs.push_back(mk(0, 1, 0, 32'h500,   0, 0, 0,   1, 0, 0, 32'h0,   0, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,     1, 0, 0,   1, 1, 1, 32'h500, 0, 1));
        vecs.push_back(mk(0, 0, 0, 32'h0,     0, 0, 1,   1, 0, 0, 32'h0,   0, 0));
        vecs.push_back(mk(1, 0, 0, 32'h0,     1, 0, 0,   0, 0, 0, 32'h0,   0, 1));
        vecs.push_back(mk(0, 0, 0, 32'h0,     0, 0, 0,   1, 0, 0, 32'h0,   0, 1));

        foreach (vecs[i]) begin
            @(negedge clk);
            rst2                  = vecs[i].rst;
            bus2.instr_valid_i    = vecs[i].vld;
            bus2.is_load_i        = vecs[i].ld;
            bus2.instr_i          = vecs[i].instr;
            bus2.mem_gnt_i        = vecs[i].gnt;
            bus2.load_mem_resp_i  = vecs[i].lr;
            bus2.store_mem_resp_i = vecs[i].sr;
            #1;
            check($sformatf("v%0d ready", i), 32'(bus2.ready_o), 32'(vecs[i].e_rdy));
            check($sformatf("v%0d req", i), 32'(bus2.mem_req_o), 32'(vecs[i].e_req));
            check($sformatf("v%0d full", i), 32'(bus2.stq_full_o), 32'(vecs[i].e_full));
            if (vecs[i].chk_wa) begin
                check($sformatf("v%0d we", i), 32'(bus2.mem_we_o), 32'(vecs[i].e_we));
                check($sformatf("v%0d addr", i), bus2.mem_addr_o, vecs[i].e_addr);
            end
        end

        @(negedge clk);
        bus2.instr_valid_i = 1'b0;  bus2.mem_gnt_i = 1'b0;
        bus2.load_mem_resp_i = 1'b0;  bus2.store_mem_resp_i = 1'b0;

        // 4-entry queue: popping the in-flight store as a load is accepted leaves an
        // unissued store and a pending load both eligible with the queue not full
        rst4 = 1'b0;
        drive4(1'b1, 1'b0, 32'h100, 1'b0, 1'b0, 1'b0);
        #1;  check4("q4 st100", 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        drive4(1'b1, 1'b0, 32'h200, 1'b1, 1'b0, 1'b0);
        #1;  check4("q4 st200", 1'b1, 1'b1, 1'b1, 32'h100, 1'b0);
        @(negedge clk);
        drive4(1'b1, 1'b1, 32'h300, 1'b0, 1'b0, 1'b1);
        #1;  check4("q4 ld300", 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        drive4(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        #1;  check4("q4 arb", 1'b0, 1'b1, 1'b0, 32'h300, 1'b0);
        @(negedge clk);
        drive4(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        #1;  check4("q4 st next", 1'b0, 1'b1, 1'b1, 32'h200, 1'b0);
        @(negedge clk);
        drive4(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        #1;  check4("q4 st held", 1'b0, 1'b1, 1'b1, 32'h200, 1'b0);
        @(negedge clk);
        drive4(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        #1;  check4("q4 drained", 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
